// File: rtl/cpu_run_controller_pkg.sv
// Shared types for the CPU run controller: run-state encoding and
// fixed-width vector aliases used across the controller files.
package global_types;

    typedef logic [15:0] logic16;
    typedef logic [31:0] logic32;

    // Encodings are visible on the debug LEDs, so they are fixed
    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        BURST  = 2'd2,
        BREAK  = 2'd3
    } run_state_t;

endpackage

// File: rtl/cpu_run_controller_pulse_divider.sv
// Rate divider for RUN/BURST: while enabled, asserts tick once every
// RUN_DIV enabled cycles. Clear restarts the count from zero.
import global_types::*;

module pulse_divider #(
    parameter logic [31:0] RUN_DIV = 32'd50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic32 count;

    assign tick = enable && !clear && (count == RUN_DIV - 32'd1);

    // Count enabled cycles, wrapping to zero on the cycle that ticks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 32'd1;
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Execution controller for the MIPS core: issues one-cycle cpu_en pulses
// for single-step, free-run and counted-burst modes.
// Optional feature macro: RUN_CTRL_BREAKPOINT_EN enables the PC breakpoint
// compare and the BREAK state; without it bp_addr/bp_valid are ignored.
import global_types::*;

module cpu_run_controller #(
    parameter logic [31:0] RUN_DIV = 32'd50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        halt,
    input  logic        burst_start,
    input  logic [15:0] burst_count,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
    output logic        cpu_en,
    output logic [1:0]  run_state,
    output logic        bp_hit,
    output logic [31:0] retired
);

    run_state_t state;
    logic16     remaining;
    logic       step_prev;
    logic       step_edge;
    logic       bp_match;
    logic       running;
    logic       div_clear;
    logic       div_enable;
    logic       tick;
    logic       issue;

`ifdef RUN_CTRL_BREAKPOINT_EN
    assign bp_match = bp_valid && (pc == bp_addr);
`else
    // Breakpoint inputs stay on the port list but have no effect
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_match  = 1'b0;
`endif

    assign step_edge  = step_btn && !step_prev;
    assign running    = (state == RUN) || (state == BURST);
    // Divider sits at zero whenever we are not running, so entering
    // RUN/BURST always starts a fresh RUN_DIV interval
    assign div_clear  = !running;
    assign div_enable = running && !halt && !bp_match;

    pulse_divider #(
        .RUN_DIV (RUN_DIV)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .clear  (div_clear),
        .enable (div_enable),
        .tick   (tick)
    );

    // A pulse is issued on a step edge from HALTED/BREAK, or on a divider tick
    always_comb begin
        issue = 1'b0;
        case (state)
            HALTED:    issue = step_edge;
            RUN,
            BURST:     issue = tick;
            BREAK:     issue = step_edge;
            default:   issue = 1'b0;
        endcase
    end

    assign run_state = state;

    // Retired-instruction counter, advancing together with cpu_en
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (issue) begin
            retired <= retired + 32'd1;
        end
    end

    // Run-mode FSM with registered cpu_en and bp_hit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= HALTED;
            cpu_en    <= 1'b0;
            bp_hit    <= 1'b0;
            remaining <= '0;
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_btn;
            cpu_en    <= issue;
            case (state)
                HALTED: begin
                    if (step_edge) begin
                        state <= HALTED;
                    end else if (burst_start && (burst_count != 16'd0)) begin
                        remaining <= burst_count;
                        state     <= BURST;
                    end else if (run_sw) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (bp_match) begin
                        state  <= BREAK;
                        bp_hit <= 1'b1;
                    end else if (!tick && !run_sw) begin
                        state <= HALTED;
                    end
                end
                BURST: begin
                    if (halt) begin
                        state     <= HALTED;
                        remaining <= '0;
                    end else if (bp_match) begin
                        state  <= BREAK;
                        bp_hit <= 1'b1;
                    end else if (tick) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= HALTED;
                        end
                    end
                end
                BREAK: begin
                    // Any exit from BREAK drops the unfinished burst
                    if (step_edge || !run_sw || halt) begin
                        state     <= HALTED;
                        bp_hit    <= 1'b0;
                        remaining <= '0;
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller with RUN_DIV=4: vector table, directed
// multi-cycle scenarios and a randomized run against a reference model.
module tb_cpu_run_controller;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        step_btn, run_sw, halt, burst_start;
    logic [15:0] burst_count;
    logic [31:0] pc, bp_addr;
    logic        bp_valid;
    logic        cpu_en;
    logic [1:0]  run_state;
    logic        bp_hit;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_run_controller #(.RUN_DIV(DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .step_btn    (step_btn),
        .run_sw      (run_sw),
        .halt        (halt),
        .burst_start (burst_start),
        .burst_count (burst_count),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .cpu_en      (cpu_en),
        .run_state   (run_state),
        .bp_hit      (bp_hit),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          step;
        bit          run;
        bit          hlt;
        bit          bstart;
        logic [15:0] bcount;
        bit          exp_en;
        int          exp_state;
        int          exp_ret;
    } vec_t;

    vec_t vecs [19];

    // Reference model: mode, active cycles since entering RUN/BURST,
    // instructions left in the burst, previous step level, retired count.
    int          m_state;
    int          m_k;
    int          m_rem;
    bit          m_prev;
    bit          m_en;
    logic [31:0] m_ret;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clk_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        step_btn    = 1'b0;
        run_sw      = 1'b0;
        halt        = 1'b0;
        burst_start = 1'b0;
        burst_count = 16'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        clk_step();
        clk_step();
        reset = 1'b0;
        m_state = 0; m_k = 0; m_rem = 0; m_prev = 1'b0; m_en = 1'b0; m_ret = '0;
    endtask

    // Predict the outputs after the coming edge from the current inputs
    task automatic model_edge();
        bit edge_seen;
        bit bpm;
        edge_seen = step_btn && !m_prev;
`ifdef RUN_CTRL_BREAKPOINT_EN
        bpm = bp_valid && (pc == bp_addr);
`else
        bpm = 1'b0;
`endif
        m_en = 1'b0;
        if (m_state == 0) begin
            if (edge_seen) m_en = 1'b1;
            else if (burst_start && burst_count != 0) begin
                m_rem = burst_count; m_state = 2; m_k = 0;
            end else if (run_sw) begin
                m_state = 1; m_k = 0;
            end
        end else if (m_state == 1 || m_state == 2) begin
            if (halt) m_state = 0;
            else if (bpm) m_state = 3;
            else begin
                m_k++;
                if (m_k % DIV == 0) begin
                    m_en = 1'b1;
                    if (m_state == 2) begin
                        m_rem--;
                        if (m_rem == 0) m_state = 0;
                    end
                end else if (m_state == 1 && !run_sw) m_state = 0;
            end
        end else begin
            if (edge_seen) begin m_en = 1'b1; m_state = 0; end
            else if (!run_sw || halt) m_state = 0;
        end
        if (m_en) m_ret = m_ret + 32'd1;
        m_prev = step_btn;
    endtask

    initial begin
        int pulses;
        vec_t v;

        // step run halt bstart bcount | en state retired
        vecs[0]  = '{0, 0, 0, 0, 16'd0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 16'd0, 1, 0, 1};
        vecs[2]  = '{1, 0, 0, 0, 16'd0, 0, 0, 1};
        vecs[3]  = '{0, 0, 0, 0, 16'd0, 0, 0, 1};
        vecs[4]  = '{0, 0, 0, 1, 16'd0, 0, 0, 1};
        vecs[5]  = '{0, 0, 0, 1, 16'd2, 0, 2, 1};
        vecs[6]  = '{0, 0, 0, 0, 16'd0, 0, 2, 1};
        vecs[7]  = '{0, 0, 0, 0, 16'd0, 0, 2, 1};
        vecs[8]  = '{0, 0, 0, 0, 16'd0, 0, 2, 1};
        vecs[9]  = '{0, 0, 0, 0, 16'd0, 1, 2, 2};
        vecs[10] = '{0, 0, 0, 0, 16'd0, 0, 2, 2};
        vecs[11] = '{0, 0, 0, 0, 16'd0, 0, 2, 2};
        vecs[12] = '{0, 0, 0, 0, 16'd0, 0, 2, 2};
        vecs[13] = '{0, 0, 0, 0, 16'd0, 1, 0, 3};
        vecs[14] = '{0, 1, 0, 0, 16'd0, 0, 1, 3};
        vecs[15] = '{0, 0, 0, 0, 16'd0, 0, 0, 3};
        vecs[16] = '{1, 1, 0, 0, 16'd0, 1, 0, 4};
        vecs[17] = '{1, 1, 0, 0, 16'd0, 0, 1, 4};
        vecs[18] = '{0, 1, 1, 0, 16'd0, 0, 0, 4};

        pc = 32'd0; bp_addr = 32'h10; bp_valid = 1'b0;
        idle_inputs();
        reset = 1'b1;
        #2;
        check("reset_cpu_en", cpu_en, 0);
        check("reset_state", run_state, 0);
        check("reset_bp_hit", bp_hit, 0);
        check("reset_retired", retired, 0);
        do_reset();

        // Vector table
        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            step_btn = v.step; run_sw = v.run; halt = v.hlt;
            burst_start = v.bstart; burst_count = v.bcount;
            clk_step();
            check($sformatf("vec%0d_en", i), cpu_en, v.exp_en);
            check($sformatf("vec%0d_state", i), run_state, v.exp_state);
            check($sformatf("vec%0d_ret", i), retired, v.exp_ret);
        end

        // Single step at cycle 10: exactly one pulse
        do_reset();
        for (int i = 0; i < 10; i++) clk_step();
        step_btn = 1'b1;
        clk_step();
        check("step_pulse", cpu_en, 1);
        clk_step();
        check("step_one_cycle", cpu_en, 0);
        clk_step();
        check("step_retired", retired, 1);
        check("step_state", run_state, 0);
        step_btn = 1'b0;

        // Free run: pulses every DIV cycles after entry, then stop
        do_reset();
        run_sw = 1'b1;
        clk_step();
        check("run_entry", run_state, 1);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            clk_step();
            check($sformatf("run_c%0d", i), cpu_en, (i % DIV == 0));
            if (cpu_en) pulses++;
        end
        check("run_pulses", pulses, 5);
        check("run_retired", retired, 5);
        run_sw = 1'b0;
        clk_step();
        check("run_stop", run_state, 0);

        // Burst of 3, then burst of 0
        do_reset();
        burst_start = 1'b1; burst_count = 16'd3;
        clk_step();
        burst_start = 1'b0;
        check("burst_entry", run_state, 2);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            clk_step();
            check($sformatf("burst_c%0d", i), cpu_en, (i % DIV == 0) && (i <= 12));
            if (cpu_en) pulses++;
        end
        check("burst_pulses", pulses, 3);
        check("burst_done", run_state, 0);
        burst_start = 1'b1; burst_count = 16'd0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            clk_step();
            burst_start = 1'b0;
            if (cpu_en) pulses++;
        end
        check("burst0_pulses", pulses, 0);
        check("burst0_state", run_state, 0);

        // Breakpoint: pc advances by 4 the cycle after each pulse
        do_reset();
        pc = 32'd0; bp_addr = 32'h10; bp_valid = 1'b1;
        run_sw = 1'b1;
        clk_step();
        for (int i = 1; i <= 17; i++) begin
            clk_step();
            if (cpu_en) pc = pc + 32'd4;
        end
        check("bp_retired", retired, 4);
`ifdef RUN_CTRL_BREAKPOINT_EN
        check("bp_state", run_state, 3);
        check("bp_hit", bp_hit, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            clk_step();
            if (cpu_en) pulses++;
        end
        check("bp_no_pulse", pulses, 0);
        check("bp_hold", run_state, 3);
        step_btn = 1'b1;
        clk_step();
        check("bp_step_pulse", cpu_en, 1);
        check("bp_step_state", run_state, 0);
        check("bp_step_hit", bp_hit, 0);
`else
        check("bp_ignored_state", run_state, 1);
        check("bp_ignored_hit", bp_hit, 0);
`endif
        run_sw = 1'b0; step_btn = 1'b0; bp_valid = 1'b0;

        // Halt in the cycle a pulse is due
        do_reset();
        run_sw = 1'b1;
        clk_step();
        for (int i = 0; i < 3; i++) clk_step();
        halt = 1'b1;
        clk_step();
        check("halt_no_pulse", cpu_en, 0);
        check("halt_state", run_state, 0);
        check("halt_retired", retired, 0);
        halt = 1'b0; run_sw = 1'b0;

        // Reset mid-burst, with a pulse in flight
        do_reset();
        burst_start = 1'b1; burst_count = 16'd4;
        clk_step();
        burst_start = 1'b0;
        for (int i = 0; i < 8; i++) clk_step();
        check("mid_pulse_inflight", cpu_en, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_en", cpu_en, 0);
        check("mid_rst_state", run_state, 0);
        check("mid_rst_ret", retired, 0);
        check("mid_rst_hit", bp_hit, 0);
        clk_step();
        reset = 1'b0;
        run_sw = 1'b1;
        clk_step();
        check("post_rst_entry", run_state, 1);
        pulses = 0;
        for (int i = 1; i <= 4; i++) begin
            clk_step();
            check($sformatf("post_rst_c%0d", i), cpu_en, (i == 4));
        end
        run_sw = 1'b0;

        // Randomized run against the reference model
        do_reset();
        bp_addr = 32'h40;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
            halt        = ($urandom_range(0, 24) == 0);
            burst_start = ($urandom_range(0, 14) == 0);
            burst_count = 16'($urandom_range(0, 4));
            bp_valid    = ($urandom_range(0, 3) != 0);
            pc          = ($urandom_range(0, 5) == 0) ? 32'h40 : 32'($urandom_range(0, 15) * 4);
            model_edge();
            clk_step();
            check("rnd_en", cpu_en, m_en);
            check("rnd_state", run_state, m_state);
            check("rnd_hit", bp_hit, (m_state == 3));
            check("rnd_ret", retired, m_ret);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
